// File: rtl/ice_def_pkg.sv
// Shared defaults for the ICE UART buffers.
`ifndef SD
`define SD
`endif

package ice_def;

    localparam int unsigned ICE_UART_FIFO_DEPTH_LOG2 = 4;
    localparam int unsigned ICE_UART_FIFO_HIGH_WATER = 12;
    localparam int unsigned ICE_UART_FIFO_WIDTH      = 8;

endpackage

// File: rtl/ice_fifo_regfile.sv
// Register array for the ICE UART FIFOs: one synchronous write port, one async read port.
`ifndef SD
`define SD
`endif

module ice_fifo_regfile #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WIDTH  = 8
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    // Storage has no reset; the owner masks stale contents while empty.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= `SD wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ice_uart_rx_fifo.sv
// Receive-side first-word-fall-through byte buffer between the UART receiver and the ICE bus
// controller, with registered occupancy, almost-full and sticky overflow status.
`ifndef SD
`define SD
`endif

module ice_uart_rx_fifo
    import ice_def::*;
#(
    parameter int unsigned DEPTH_LOG2 = ICE_UART_FIFO_DEPTH_LOG2,
    parameter int unsigned WIDTH      = ICE_UART_FIFO_WIDTH,
    parameter int unsigned HIGH_WATER = ICE_UART_FIFO_HIGH_WATER
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_latch,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  overflow_clear
);

    localparam int unsigned PtrW = DEPTH_LOG2 + 1;
    localparam logic [PtrW-1:0] Depth     = PtrW'(2 ** DEPTH_LOG2);
    localparam logic [PtrW-1:0] HighWater = PtrW'(HIGH_WATER);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] level_q, level_d;
    logic            almost_full_q, almost_full_d;
    logic            overflow_q, overflow_d;

    logic             full, empty, pop, push, drop, wr_en;
    logic [WIDTH-1:0] rd_data;

    // Handshake decode from the registered occupancy.
    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == Depth);
        pop   = !empty && out_ready;
        // A pop in the same cycle frees the slot the full-push lands in.
        push  = in_latch && (!full || pop);
        drop  = in_latch && full && !pop && !flush;
        wr_en = push && !flush;
    end

    // Next pointers and status; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        level_d       = wr_ptr_d - rd_ptr_d;
        almost_full_d = (level_d >= HighWater);
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= `SD '0;
            rd_ptr_q      <= `SD '0;
            level_q       <= `SD '0;
            almost_full_q <= `SD 1'b0;
            overflow_q    <= `SD 1'b0;
        end else begin
            wr_ptr_q      <= `SD wr_ptr_d;
            rd_ptr_q      <= `SD rd_ptr_d;
            level_q       <= `SD level_d;
            almost_full_q <= `SD almost_full_d;
            overflow_q    <= `SD overflow_d;
        end
    end

    ice_fifo_regfile #(
        .ADDR_W (DEPTH_LOG2),
        .WIDTH  (WIDTH)
    ) u_regfile (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o (rd_data)
    );

    // Stale array contents are hidden while empty.
    always_comb begin
        out_valid   = !empty;
        out_data    = empty ? '0 : rd_data;
        level       = level_q;
        almost_full = almost_full_q;
        overflow    = overflow_q;
    end

endmodule
